// File: rtl/butterfly_pkg.sv
// Shared ButterFly core types: redirect source/state encodings and drain counter width.
package butterfly_pkg;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_BRANCH = 2'd1,
        SRC_JUMP   = 2'd2,
        SRC_TRAP   = 2'd3
    } redir_src_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DRAIN   = 2'd2
    } redir_state_e;

    localparam int DRAIN_W = 4;

endpackage

// File: rtl/redirect_ctrl.sv
// PC redirect sequencer: arbitrates trap/jump/branch, hands one registered redirect
// to fetch, and holds flush/stall until acceptance plus a drain window.
module redirect_ctrl
    import butterfly_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 1,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        trap_i,
    input  logic [31:0] trap_target_i,
    input  logic        redirect_ready_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic [1:0]  redirect_src_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [31:0] redirect_cnt_o
);

    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        (DRAIN_CYCLES == 0) ? '0 : DRAIN_W'(DRAIN_CYCLES - 1);

    redir_state_e       state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic        req_any, req_mis;
    logic [31:0] req_pc;
    redir_src_e  req_src;

    logic        lat;
    logic [31:0] lat_pc;
    redir_src_e  lat_src;
    logic        handshake;

    logic        valid_d, flush_d, stall_d, mis_d;
    logic [31:0] pc_d, cnt_d;
    logic [1:0]  src_d;

    // Trap wins and is never alignment-checked; only the winner's alignment matters.
    always_comb begin
        req_any = 1'b0;
        req_mis = 1'b0;
        req_pc  = '0;
        req_src = SRC_NONE;
        if (trap_i) begin
            req_any = 1'b1;
            req_pc  = trap_target_i;
            req_src = SRC_TRAP;
        end else if (jump_i) begin
            req_any = 1'b1;
            req_mis = (jump_target_i[1:0] != 2'b00);
            req_pc  = jump_target_i;
            req_src = SRC_JUMP;
        end else if (br_taken_i) begin
            req_any = 1'b1;
            req_mis = (br_target_i[1:0] != 2'b00);
            req_pc  = br_target_i;
            req_src = SRC_BRANCH;
        end
    end

    assign handshake = (state_q == PENDING) && redirect_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        lat     = 1'b0;
        lat_pc  = trap_target_i;
        lat_src = SRC_TRAP;
        unique case (state_q)
            IDLE: begin
                if (req_any && !req_mis) begin
                    state_d = PENDING;
                    lat     = 1'b1;
                    lat_pc  = req_pc;
                    lat_src = req_src;
                end
            end
            PENDING: begin
                // A trap either preempts the pending redirect or chains right after it.
                if (trap_i) begin
                    lat = 1'b1;
                end else if (redirect_ready_i) begin
                    state_d = (DRAIN_CYCLES > 0) ? DRAIN : IDLE;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (trap_i) begin
                    state_d = PENDING;
                    lat     = 1'b1;
                end else if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = (state_d == PENDING);
        flush_d = (state_d == PENDING);
        stall_d = (state_d != IDLE);
        mis_d   = (state_q == IDLE) && req_any && req_mis;
        pc_d    = lat ? lat_pc : redirect_pc_o;
        src_d   = lat ? lat_src : redirect_src_o;
        cnt_d   = redirect_cnt_o + {31'd0, handshake};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= RESET_PC;
            redirect_src_o   <= SRC_NONE;
            flush_o          <= 1'b0;
            stall_o          <= 1'b0;
            misalign_o       <= 1'b0;
            redirect_cnt_o   <= '0;
        end else begin
            redirect_valid_o <= valid_d;
            redirect_pc_o    <= pc_d;
            redirect_src_o   <= src_d;
            flush_o          <= flush_d;
            stall_o          <= stall_d;
            misalign_o       <= mis_d;
            redirect_cnt_o   <= cnt_d;
        end
    end

endmodule
